date_ctrl: RTL and testbench
============================

Name: date_ctrl

Overview:
- Sequencer for six cascaded BCD date-digit counters: day ones/tens, month ones/tens, year ones/tens. Years are 2000–2099.
- Each counter holds on stop=1, increments or wraps max→min on stop=0, and reloads its init value on opr_rst=0.
- This block reads the current digit values, decides which counters advance or reload, and handles month length, leap years and a button-driven set mode.
- Counter init values (day 01, month 01, year 00) are tied at top level.

Parameters:
- DIG_W, 4, BCD digit width. Fixed 4; the parameter only names widths.
- BLINK_DIV, 1, ticks per blink toggle. Used only with DATE_BLINK_EN.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle pulse meaning "advance one day".
- mode_pb  input  1  debounced one-cycle pulse that cycles the mode.
- inc_pb  input  1  debounced one-cycle pulse that increments the selected field.
- day_o, day_t, mon_o, mon_t, yr_o, yr_t  input  4 each  current counter values.
- stop  output  6  per-digit hold. 1 = hold. Bit order: 0 day_o, 1 day_t, 2 mon_o, 3 mon_t, 4 yr_o, 5 yr_t.
- opr_rst  output  6  per-digit synchronous reload-to-init, active-low. Same bit order as stop.
- mode  output  2  0 RUN, 1 SET_YR, 2 SET_MON, 3 SET_DAY.
- busy  output  1  high while a pulse is in flight.
- blink  output  6  digit blank mask (see Optional Feature).

Behaviour:
- Reset (rst=0): mode=RUN, stop=6'b111111, opr_rst=6'b111111, busy=0, blink=0, pending flags cleared.
- All outputs are registered.
- Sub-FSM states: IDLE → APPLY → SETTLE → IDLE, plus CHECK used in set modes.
  - Event accepted at edge k in IDLE: stop/opr_rst pulse is driven for exactly one cycle (k..k+1).
  - Counters update at edge k+1.
  - SETTLE lasts one cycle so the new digit values are visible.
  - busy=1 from edge k to return to IDLE.
- Day advance (tick in RUN, or inc_pb in SET_DAY):
  - last = days in month (mon_t:mon_o). Leap year = (yr_t even and yr_o∈{0,4,8}) or (yr_t odd and yr_o∈{2,6}); Feb = 29 if leap, else 28.
  - Date is not the last day: stop[0]=0. Also stop[1]=0 if day_o==9.
  - Date is the last day: opr_rst[1:0]=0 (day reloads to 01).
  - In RUN only, a last-day rollover also advances the month.
- Month advance (RUN rollover, or inc_pb in SET_MON):
  - Month 12: opr_rst[3:2]=0 (reload to 01). In RUN this also advances the year.
  - Any other month: stop[2]=0, plus stop[3]=0 if mon_o==9.
- Year advance (RUN rollover, or inc_pb in SET_YR):
  - stop[4]=0, plus stop[5]=0 if yr_o==9.
  - 99→00 uses the counters' natural wrap.
- All digit actions for one event are issued in the same APPLY cycle.
  - Digits that neither advance nor reload keep stop=1, opr_rst=1.
- Mode FSM:
  - mode_pb cycles RUN→SET_YR→SET_MON→SET_DAY→RUN.
  - The mode change takes effect at the next edge when IDLE.
- Event filtering:
  - In RUN, inc_pb is ignored.
  - In set modes, tick is ignored and discarded, not queued.
- CHECK: after any SET_YR or SET_MON increment, and on the SET_DAY→RUN transition, one extra cycle compares the day with last. If day > last, opr_rst[1:0]=0 (day → 01).
- Events arriving while busy:
  - A tick or mode_pb is latched in a one-deep pending flag and serviced on return to IDLE.
  - A second pulse of the same kind while its flag is set is dropped.
  - inc_pb while busy is dropped.
  - If tick and mode_pb are pending together, tick is serviced first.
- Simultaneous tick and mode_pb in IDLE in RUN: the tick is serviced, and mode_pb becomes pending.
- Reset mid-pulse: outputs return to reset values immediately. No partial reload is guaranteed beyond what the counters have already latched.

Optional Feature:
- Macro: DATE_BLINK_EN.
- Defined:
  - In set modes, the selected field's two blink bits toggle every BLINK_DIV ticks; ticks are still ignored for the date.
  - Fields: SET_YR → bits 5:4, SET_MON → 3:2, SET_DAY → 1:0.
  - The blink phase restarts visible (0) on each mode change.
  - blink=0 in RUN.
- Undefined: blink is tied to 6'b0 and no blink counter is synthesised.

Test Plan:
- Date 2023-02-28, RUN, tick → opr_rst[1:0]=0 and stop[2]=0 in the same cycle; date becomes 2023-03-01; busy high 2 cycles.
- Date 2024-02-28, tick → 2024-02-29; second tick → 2024-03-01.
- Date 2099-12-31, tick → opr_rst[3:0]=0, stop[4]=stop[5]=0; date becomes 2000-01-01.
- Date 2024-01-31 in SET_MON, inc_pb → month 02, then CHECK reloads day to 01; date becomes 2024-02-01.
- Date 2024-01-09, RUN, tick then a second tick 1 cycle later (while busy) → both serviced in order; date becomes 2024-01-11.
- mode_pb ×4 from RUN → mode goes 1,2,3,0. With DATE_BLINK_EN and BLINK_DIV=1 in SET_DAY, each tick toggles blink between 6'b000011 and 0, and the date is unchanged.

Source files
------------

// File: rtl/date_ctrl.sv
// Date-digit sequencer: steers six cascaded BCD counters (day/month/year 2000-2099)
// for daily advance, leap years and button set mode. Optional blink mask: DATE_BLINK_EN.
module date_ctrl #(
  parameter int DIG_W     = 4,
  parameter int BLINK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             mode_pb,
  input  logic             inc_pb,
  input  logic [DIG_W-1:0] day_o,
  input  logic [DIG_W-1:0] day_t,
  input  logic [DIG_W-1:0] mon_o,
  input  logic [DIG_W-1:0] mon_t,
  input  logic [DIG_W-1:0] yr_o,
  input  logic [DIG_W-1:0] yr_t,
  output logic [5:0]       stop,
  output logic [5:0]       opr_rst,
  output logic [1:0]       mode,
  output logic             busy,
  output logic [5:0]       blink
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK} sub_e;
  typedef enum logic [1:0] {M_RUN = 2'd0, M_SET_YR = 2'd1, M_SET_MON = 2'd2, M_SET_DAY = 2'd3} mode_e;
  typedef enum logic [2:0] {EV_NONE, EV_TICK, EV_DAY, EV_MON, EV_YR, EV_CHECK} ev_e;

  if (BLINK_DIV < 1) begin : g_div_chk
    $error("BLINK_DIV must be at least 1");
  end

  sub_e  r_state, w_state_nxt;
  mode_e r_mode, w_mode_nxt;
  ev_e   w_ev;
  logic  r_pend_tick, w_pend_tick_nxt;
  logic  r_pend_mode, w_pend_mode_nxt;
  logic  r_chk, w_chk_nxt;
  logic  r_busy;
  logic [5:0] r_stop, r_opr, w_stop_nxt, w_opr_nxt;
  logic  w_tick_ev, w_mode_ev, w_leap, w_do_mon, w_do_yr;
  logic [2*DIG_W-1:0] w_day, w_mon, w_last;

  assign w_tick_ev = tick | r_pend_tick;
  assign w_mode_ev = mode_pb | r_pend_mode;
  assign w_day     = {day_t, day_o};
  assign w_mon     = {mon_t, mon_o};
  assign w_leap    = yr_t[0] ? (yr_o == 4'd2 || yr_o == 4'd6)
                             : (yr_o == 4'd0 || yr_o == 4'd4 || yr_o == 4'd8);

  // Last day of the current month, kept in BCD so it compares directly with the digits
  always_comb begin
    if (w_mon == 8'h02)
      w_last = w_leap ? 8'h29 : 8'h28;
    else if (w_mon == 8'h04 || w_mon == 8'h06 || w_mon == 8'h09 || w_mon == 8'h11)
      w_last = 8'h30;
    else
      w_last = 8'h31;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mode      <= M_RUN;
      r_pend_tick <= 1'b0;
      r_pend_mode <= 1'b0;
      r_chk       <= 1'b0;
      r_busy      <= 1'b0;
      r_stop      <= '1;
      r_opr       <= '1;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_pend_tick <= w_pend_tick_nxt;
      r_pend_mode <= w_pend_mode_nxt;
      r_chk       <= w_chk_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_stop      <= w_stop_nxt;
      r_opr       <= w_opr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mode_nxt      = r_mode;
    w_pend_tick_nxt = r_pend_tick;
    w_pend_mode_nxt = r_pend_mode;
    w_chk_nxt       = r_chk;
    w_ev            = EV_NONE;
    case (r_state)
      S_IDLE: begin
        w_pend_tick_nxt = 1'b0;
        w_pend_mode_nxt = 1'b0;
        if (w_tick_ev && r_mode == M_RUN) begin
          w_ev            = EV_TICK;
          w_state_nxt     = S_APPLY;
          w_chk_nxt       = 1'b0;
          w_pend_mode_nxt = w_mode_ev;
        end else if (w_mode_ev) begin
          w_mode_nxt = mode_e'(r_mode + 2'd1);
          if (r_mode == M_SET_DAY) begin
            w_ev        = EV_CHECK;
            w_state_nxt = S_CHECK;
          end
        end else if (inc_pb && r_mode != M_RUN) begin
          w_state_nxt = S_APPLY;
          w_chk_nxt   = (r_mode != M_SET_DAY);
          case (r_mode)
            M_SET_YR:  w_ev = EV_YR;
            M_SET_MON: w_ev = EV_MON;
            default:   w_ev = EV_DAY;
          endcase
        end
      end
      S_APPLY: w_state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (r_chk) begin
          w_ev        = EV_CHECK;
          w_state_nxt = S_CHECK;
          w_chk_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Set-mode ticks are discarded outright rather than queued
    if (r_state != S_IDLE) begin
      if (tick && r_mode == M_RUN) w_pend_tick_nxt = 1'b1;
      if (mode_pb)                 w_pend_mode_nxt = 1'b1;
    end
  end

  always_comb begin
    w_stop_nxt = '1;
    w_opr_nxt  = '1;
    w_do_mon   = 1'b0;
    w_do_yr    = 1'b0;
    case (w_ev)
      EV_TICK, EV_DAY: begin
        if (w_day == w_last) begin
          w_opr_nxt[1:0] = '0;
          w_do_mon       = (w_ev == EV_TICK);
        end else begin
          w_stop_nxt[0] = 1'b0;
          if (day_o == 4'd9) w_stop_nxt[1] = 1'b0;
        end
      end
      EV_MON:   w_do_mon = 1'b1;
      EV_YR:    w_do_yr  = 1'b1;
      EV_CHECK: if (w_day > w_last) w_opr_nxt[1:0] = '0;
      default: ;
    endcase
    if (w_do_mon) begin
      if (w_mon == 8'h12) begin
        w_opr_nxt[3:2] = '0;
        w_do_yr        = (w_ev == EV_TICK);
      end else begin
        w_stop_nxt[2] = 1'b0;
        if (mon_o == 4'd9) w_stop_nxt[3] = 1'b0;
      end
    end
    if (w_do_yr) begin
      w_stop_nxt[4] = 1'b0;
      if (yr_o == 4'd9) w_stop_nxt[5] = 1'b0;
    end
  end

  assign stop    = r_stop;
  assign opr_rst = r_opr;
  assign mode    = r_mode;
  assign busy    = r_busy;

`ifdef DATE_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] r_blink_cnt, w_cnt_nxt;
  logic          r_phase, w_phase_nxt;
  logic [5:0]    r_blink, w_mask;

  always_comb begin
    w_cnt_nxt   = r_blink_cnt;
    w_phase_nxt = r_phase;
    if (w_mode_nxt != r_mode) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else if (tick && r_mode != M_RUN) begin
      if (r_blink_cnt == CW'(BLINK_DIV - 1)) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_cnt_nxt = r_blink_cnt + 1'b1;
      end
    end
    case (w_mode_nxt)
      M_SET_YR:  w_mask = 6'b110000;
      M_SET_MON: w_mask = 6'b001100;
      M_SET_DAY: w_mask = 6'b000011;
      default:   w_mask = 6'b000000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_blink     <= '0;
    end else begin
      r_blink_cnt <= w_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_blink     <= w_phase_nxt ? w_mask : 6'b000000;
    end
  end

  assign blink = r_blink;
`else
  assign blink = '0;
`endif

endmodule

// File: tb/tb_date_ctrl.sv
// Bench for date_ctrl: models the six external BCD counters, runs a table of RUN-mode
// ticks, hand sequences for timing corners, then random events against a calendar model.
module tb_date_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, mode_pb = 1'b0, inc_pb = 1'b0;
  logic [3:0] dig [6];
  logic [5:0] stop, opr_rst, blink;
  logic [1:0] mode;
  logic       busy;

  logic       ld = 1'b0;
  logic [3:0] ld_val [6];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  date_ctrl #(.DIG_W(4), .BLINK_DIV(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_pb(mode_pb), .inc_pb(inc_pb),
    .day_o(dig[0]), .day_t(dig[1]), .mon_o(dig[2]), .mon_t(dig[3]),
    .yr_o(dig[4]), .yr_t(dig[5]),
    .stop(stop), .opr_rst(opr_rst), .mode(mode), .busy(busy), .blink(blink)
  );

  // External digit counters: reload to init (day 01, month 01, year 00), else step mod 10
  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (ld)               dig[i] <= ld_val[i];
      else if (!opr_rst[i]) dig[i] <= (i == 0 || i == 2) ? 4'd1 : 4'd0;
      else if (!stop[i])    dig[i] <= (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] date_now();
    return (dig[5] * 10 + dig[4]) * 10000 + (dig[3] * 10 + dig[2]) * 100 + dig[1] * 10 + dig[0];
  endfunction

  function automatic int days_in(input int y, input int m);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  task automatic set_date(input int y, input int m, input int d);
    ld_val[0] = 4'(d % 10); ld_val[1] = 4'(d / 10);
    ld_val[2] = 4'(m % 10); ld_val[3] = 4'(m / 10);
    ld_val[4] = 4'(y % 10); ld_val[5] = 4'(y / 10);
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  // ev: 0 tick, 1 mode_pb, 2 inc_pb; returns 1 ns after the accepting edge
  task automatic pulse(input int ev);
    @(negedge clk);
    case (ev)
      0: tick = 1'b1;
      1: mode_pb = 1'b1;
      default: inc_pb = 1'b1;
    endcase
    @(posedge clk);
    #1;
    tick = 1'b0; mode_pb = 1'b0; inc_pb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errs++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  typedef struct {
    int y; int m; int d;
    logic [5:0] stop;
    logic [5:0] opr;
    int exp;
  } vec_t;

  vec_t tv [13];
  int my, mm, md, mmode;
  logic [5:0] exp_blink;

  initial begin
    tv[0]  = '{23, 2, 28, 6'b111011, 6'b111100, 230301};
    tv[1]  = '{24, 2, 28, 6'b111110, 6'b111111, 240229};
    tv[2]  = '{24, 2, 29, 6'b111011, 6'b111100, 240301};
    tv[3]  = '{99, 12, 31, 6'b001111, 6'b110000, 101};
    tv[4]  = '{24, 1, 9,  6'b111100, 6'b111111, 240110};
    tv[5]  = '{23, 9, 30, 6'b110011, 6'b111100, 231001};
    tv[6]  = '{23, 4, 15, 6'b111110, 6'b111111, 230416};
    tv[7]  = '{23, 12, 31, 6'b101111, 6'b110000, 240101};
    tv[8]  = '{0, 2, 28,  6'b111110, 6'b111111, 229};
    tv[9]  = '{22, 2, 28, 6'b111011, 6'b111100, 220301};
    tv[10] = '{36, 2, 28, 6'b111110, 6'b111111, 360229};
    tv[11] = '{23, 4, 30, 6'b111011, 6'b111100, 230501};
    tv[12] = '{23, 1, 19, 6'b111100, 6'b111111, 230120};

    #2 rst = 1'b0;
    #20;
    chk("reset_stop", stop, 6'b111111);
    chk("reset_opr", opr_rst, 6'b111111);
    chk("reset_mode", mode, 0);
    chk("reset_busy", busy, 0);
    chk("reset_blink", blink, 0);
    @(negedge clk) rst = 1'b1;

    // RUN-mode day advance table
    for (int i = 0; i < 13; i++) begin
      set_date(tv[i].y, tv[i].m, tv[i].d);
      pulse(0);
      chk($sformatf("tv%0d_stop", i), stop, tv[i].stop);
      chk($sformatf("tv%0d_opr", i), opr_rst, tv[i].opr);
      chk($sformatf("tv%0d_busy0", i), busy, 1);
      @(posedge clk); #1;
      chk($sformatf("tv%0d_busy1", i), busy, 1);
      chk($sformatf("tv%0d_stop_idle", i), stop, 6'b111111);
      @(posedge clk); #1;
      chk($sformatf("tv%0d_busy2", i), busy, 0);
      chk($sformatf("tv%0d_date", i), date_now(), tv[i].exp);
    end

    // Second tick while busy is pended and serviced after return to IDLE
    set_date(24, 1, 9);
    pulse(0);
    pulse(0);
    @(posedge clk); #1;
    chk("b2b_gap_busy", busy, 0);
    @(posedge clk); #1;
    chk("b2b_second_stop", stop, 6'b111110);
    chk("b2b_second_busy", busy, 1);
    wait_idle();
    chk("b2b_date", date_now(), 240111);

    // SET_MON increment followed by CHECK day reload
    set_date(24, 1, 31);
    pulse(1);
    chk("setmon_mode1", mode, 1);
    pulse(1);
    chk("setmon_mode2", mode, 2);
    pulse(2);
    chk("setmon_stop", stop, 6'b111011);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("setmon_check_opr", opr_rst, 6'b111100);
    chk("setmon_check_busy", busy, 1);
    wait_idle();
    chk("setmon_date", date_now(), 240201);
    pulse(1);
    chk("setmon_mode3", mode, 3);
    pulse(1);
    chk("setmon_mode0", mode, 0);
    chk("setmon_exit_busy", busy, 1);
    chk("setmon_exit_opr", opr_rst, 6'b111111);
    wait_idle();

    // SET_DAY: ticks ignored for the date, blink toggles when enabled
    pulse(1); pulse(1); pulse(1);
    chk("setday_mode", mode, 3);
    set_date(23, 5, 10);
`ifdef DATE_BLINK_EN
    exp_blink = 6'b000011;
`else
    exp_blink = 6'b000000;
`endif
    pulse(0);
    chk("setday_tick_busy", busy, 0);
    chk("setday_blink1", blink, exp_blink);
    pulse(0);
    chk("setday_blink2", blink, 0);
    pulse(0);
    chk("setday_blink3", blink, exp_blink);
    @(posedge clk); #1;
    chk("setday_date_held", date_now(), 230510);
    set_date(23, 5, 31);
    pulse(2);
    chk("setday_inc_opr", opr_rst, 6'b111100);
    wait_idle();
    chk("setday_wrap_date", date_now(), 230501);
    pulse(1);
    chk("setday_exit_blink", blink, 0);
    wait_idle();
    chk("setday_exit_mode", mode, 0);

    // inc_pb ignored in RUN
    set_date(23, 5, 10);
    pulse(2);
    chk("run_inc_busy", busy, 0);
    chk("run_inc_stop", stop, 6'b111111);
    @(posedge clk); #1;
    chk("run_inc_date", date_now(), 230510);

    // Simultaneous tick and mode_pb in RUN: tick first, then mode
    set_date(23, 6, 30);
    @(negedge clk); tick = 1'b1; mode_pb = 1'b1;
    @(posedge clk); #1; tick = 1'b0; mode_pb = 1'b0;
    chk("sim_mode_hold", mode, 0);
    chk("sim_opr", opr_rst, 6'b111100);
    chk("sim_stop", stop, 6'b111011);
    wait_idle();
    @(posedge clk); #1;
    chk("sim_mode_after", mode, 1);
    chk("sim_date", date_now(), 230701);
    pulse(1); pulse(1); pulse(1);
    wait_idle();
    chk("sim_back_run", mode, 0);

    // Reset mid-pulse clears outputs immediately
    set_date(23, 6, 10);
    pulse(0);
    rst = 1'b0;
    #1;
    chk("midrst_stop", stop, 6'b111111);
    chk("midrst_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_date", date_now(), 230610);

    // Random events against the calendar model
    mmode = 0;
    for (int it = 0; it < 200; it++) begin
      int r, ev;
      if (it % 25 == 0) begin
        my = $urandom_range(0, 99);
        mm = $urandom_range(1, 12);
        md = $urandom_range(1, days_in(my, mm));
        set_date(my, mm, md);
      end
      r = $urandom_range(0, 99);
      if (mmode == 0) ev = (r < 60) ? 0 : (r < 80) ? 1 : 2;
      else            ev = (r < 55) ? 2 : (r < 80) ? 1 : 0;
      pulse(ev);
      wait_idle();
      @(posedge clk); #1;
      case (ev)
        0: if (mmode == 0) begin
             if (md < days_in(my, mm)) md++;
             else begin
               md = 1;
               if (mm < 12) mm++;
               else begin mm = 1; my = (my + 1) % 100; end
             end
           end
        1: mmode = (mmode + 1) % 4;
        default: begin
          if (mmode == 1) my = (my + 1) % 100;
          else if (mmode == 2) mm = mm % 12 + 1;
          else if (mmode == 3) md = (md == days_in(my, mm)) ? 1 : md + 1;
        end
      endcase
      if (md > days_in(my, mm)) md = 1;
      chk($sformatf("rnd%0d_date", it), date_now(), my * 10000 + mm * 100 + md);
      chk($sformatf("rnd%0d_mode", it), mode, mmode);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
